// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and constants for the valid/ready skid-buffer pipeline stage.
package pipe_skid_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam logic [1:0] LVL_EMPTY = 2'd0;
   localparam logic [1:0] LVL_ONE   = 2'd1;
   localparam logic [1:0] LVL_TWO   = 2'd2;

   localparam int DEF_WIDTH = 32;

   function automatic logic [1:0] level_of(input state_e s);
      case (s)
         ST_BUSY: return LVL_ONE;
         ST_FULL: return LVL_TWO;
         default: return LVL_EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_stage_reg_ld.sv
// Load-enabled register with asynchronous active-high reset to a parameterised value.
module pipe_reg_ld
   import pipe_skid_stage_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // NOTE: the payload register is reset on purpose so m_data reads a known
   // value out of reset; a plain datapath register would normally skip this.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= RST_VAL;
      end else if (ld_i) begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Full-throughput valid/ready register slice with a one-entry skid buffer;
// s_ready, m_valid and m_data all come straight from flops.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int               WIDTH    = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RST_DATA = '0,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       level,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] STALL_MAX = '1;
   localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic             s_ready_q, s_ready_d;
   logic             m_valid_q, m_valid_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic             s_fire, m_fire;
   logic             main_ld, skid_ld, main_from_skid;
   logic [WIDTH-1:0] main_d, main_q, skid_q;

   assign s_fire = s_valid & s_ready_q;
   assign m_fire = m_valid_q & m_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (s_fire) begin
               state_d = ST_BUSY;
               main_ld = 1'b1;
            end
         end
         ST_BUSY: begin
            if (s_fire && m_fire) begin
               main_ld = 1'b1;
            end else if (s_fire) begin
               state_d = ST_FULL;
               skid_ld = 1'b1;
            end else if (m_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (m_fire) begin
               state_d        = ST_BUSY;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush drops everything held plus any word accepted this cycle; data
      // registers keep their contents, only the occupancy is forgotten.
      if (flush) begin
         state_d = ST_EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
   end

   assign s_ready_d = (state_d != ST_FULL);
   assign m_valid_d = (state_d != ST_EMPTY);
   assign stall_d   = (m_valid_q && !m_ready && stall_q != STALL_MAX) ? stall_q + STALL_ONE
                                                                      : stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         stall_q   <= stall_d;
      end
   end

   assign main_d = main_from_skid ? skid_q : s_data;

   pipe_reg_ld #(.WIDTH(WIDTH), .RST_VAL(RST_DATA)) u_main (
      .clk  (clk),
      .rst  (rst),
      .ld_i (main_ld),
      .d_i  (main_d),
      .q_o  (main_q)
   );

   pipe_reg_ld #(.WIDTH(WIDTH), .RST_VAL(RST_DATA)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .ld_i (skid_ld),
      .d_i  (s_data),
      .q_o  (skid_q)
   );

   assign s_ready   = s_ready_q;
   assign m_valid   = m_valid_q;
   assign m_data    = main_q;
   assign level     = level_of(state_q);
   assign stall_cnt = stall_q;

   a_s_hold : assert property (@(posedge clk) disable iff (rst)
      (s_valid && !s_ready_q) |=> (s_valid && $stable(s_data)));

   a_m_hold : assert property (@(posedge clk) disable iff (rst)
      (m_valid_q && !m_ready && !flush) |=> (m_valid_q && $stable(main_q)));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: vector table, scoreboard and
// an asynchronous-reset sequence.
module tb_pipe_skid_stage;

   localparam int          WIDTH = 32;
   localparam int          CNT_W = 2;
   localparam logic [31:0] RST_D = 32'h0000_5A5A;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic [1:0]       level;
   logic [CNT_W-1:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] sb_q[$];

   typedef struct {
      logic        rst;
      logic        flush;
      logic        sv;
      logic [31:0] sd;
      logic        mr;
      logic        mv;
      logic        sr;
      logic [1:0]  lvl;
      logic [31:0] md;
      logic [1:0]  sc;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   pipe_skid_stage #(.WIDTH(WIDTH), .RST_DATA(RST_D), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .level     (level),
      .stall_cnt (stall_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic f, input logic sv, input logic [31:0] sd,
                      input logic mr, input logic mv, input logic sr, input logic [1:0] lvl,
                      input logic [31:0] md, input logic [1:0] sc);
      vec_t v;
      v = '{rst: r, flush: f, sv: sv, sd: sd, mr: mr, mv: mv, sr: sr, lvl: lvl, md: md, sc: sc};
      vecs.push_back(v);
   endtask

   // Scoreboard: samples mid-cycle the handshakes the next rising edge will act on.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else begin
         if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_underflow: got m_data %0h, expected no word", m_data);
            end else begin
               check("sb_data", m_data, sb_q.pop_front());
            end
         end
         if (flush) sb_q.delete();
         else if (s_valid && s_ready) sb_q.push_back(s_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //   rst flush sv  sd         mr | mv  sr  lvl  md          sc
      add(1, 0, 0, 32'h0, 0,   0, 0, 2'd0, RST_D, 2'd0);
      add(1, 0, 0, 32'h0, 0,   0, 0, 2'd0, RST_D, 2'd0);
      add(1, 0, 0, 32'h0, 0,   0, 0, 2'd0, RST_D, 2'd0);
      add(0, 0, 0, 32'h0, 1,   0, 1, 2'd0, RST_D, 2'd0);
      for (int k = 1; k <= 8; k++) add(0, 0, 1, k, 1,   1, 1, 2'd1, k, 2'd0);
      add(0, 0, 0, 32'h0, 1,   0, 1, 2'd0, 32'h8, 2'd0);
      // stall counter saturation
      add(0, 0, 1, 32'hC, 0,   1, 1, 2'd1, 32'hC, 2'd0);
      add(0, 0, 0, 32'h0, 0,   1, 1, 2'd1, 32'hC, 2'd1);
      add(0, 0, 0, 32'h0, 0,   1, 1, 2'd1, 32'hC, 2'd2);
      add(0, 0, 0, 32'h0, 0,   1, 1, 2'd1, 32'hC, 2'd3);
      add(0, 0, 0, 32'h0, 0,   1, 1, 2'd1, 32'hC, 2'd3);
      add(0, 0, 0, 32'h0, 0,   1, 1, 2'd1, 32'hC, 2'd3);
      add(0, 0, 0, 32'h0, 0,   1, 1, 2'd1, 32'hC, 2'd3);
      add(0, 0, 0, 32'h0, 1,   0, 1, 2'd0, 32'hC, 2'd3);
      // backpressure into the skid, then drain
      add(0, 0, 1, 32'hA, 0,   1, 1, 2'd1, 32'hA, 2'd3);
      add(0, 0, 1, 32'hB, 0,   1, 0, 2'd2, 32'hA, 2'd3);
      add(0, 0, 0, 32'h0, 1,   1, 1, 2'd1, 32'hB, 2'd3);
      add(0, 0, 0, 32'h0, 1,   0, 1, 2'd0, 32'hB, 2'd3);
      // flush while full
      add(0, 0, 1, 32'hA, 0,   1, 1, 2'd1, 32'hA, 2'd3);
      add(0, 0, 1, 32'hB, 0,   1, 0, 2'd2, 32'hA, 2'd3);
      add(0, 1, 0, 32'h0, 0,   0, 1, 2'd0, 32'hA, 2'd3);
      // word offered during flush is discarded
      add(0, 0, 1, 32'hD, 0,   1, 1, 2'd1, 32'hD, 2'd3);
      add(0, 1, 1, 32'hE, 0,   0, 1, 2'd0, 32'hD, 2'd3);
      add(0, 0, 0, 32'h0, 1,   0, 1, 2'd0, 32'hD, 2'd3);
      // flush coinciding with a delivery
      add(0, 0, 1, 32'hF, 1,   1, 1, 2'd1, 32'hF, 2'd3);
      add(0, 1, 0, 32'h0, 1,   0, 1, 2'd0, 32'hF, 2'd3);

      foreach (vecs[i]) begin
         rst     = vecs[i].rst;
         flush   = vecs[i].flush;
         s_valid = vecs[i].sv;
         s_data  = vecs[i].sd;
         m_ready = vecs[i].mr;
         @(posedge clk);
         #1;
         check($sformatf("row%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].mv));
         check($sformatf("row%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].sr));
         check($sformatf("row%0d_level", i), 32'(level), 32'(vecs[i].lvl));
         check($sformatf("row%0d_m_data", i), m_data, vecs[i].md);
         check($sformatf("row%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].sc));
      end

      // Asynchronous reset while two words are held.
      flush   = 1'b0;
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'h11;
      @(posedge clk);
      #1;
      s_data = 32'h22;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("pre_rst_level", 32'(level), 32'd2);
      check("pre_rst_stall_cnt", 32'(stall_cnt), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_m_valid", 32'(m_valid), 32'd0);
      check("async_rst_s_ready", 32'(s_ready), 32'd0);
      check("async_rst_level", 32'(level), 32'd0);
      check("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("async_rst_m_data", m_data, RST_D);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_s_ready", 32'(s_ready), 32'd1);
      check("post_rst_m_valid", 32'(m_valid), 32'd0);
      s_valid = 1'b1;
      s_data  = 32'h77;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("post_rst_xfer_m_valid", 32'(m_valid), 32'd1);
      check("post_rst_xfer_m_data", m_data, 32'h77);
      @(posedge clk);
      #1;
      check("post_rst_drain_m_valid", 32'(m_valid), 32'd0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
